// File: rtl/conv_pkg.sv
// conv_pkg: shared constants for the conv2 window generator.
//   Window geometry (FILTER_SIZE, TAPS), channel count (CHANNEL_LEN),
//   pooled conv1 feature-map geometry (POOL1_*), and tap_idx(), which maps
//   window row/column to the row-major tap number used in the flat
//   window buses.
package conv_pkg;

  localparam int FILTER_SIZE  = 5;
  localparam int CHANNEL_LEN  = 3;
  localparam int TAPS         = FILTER_SIZE * FILTER_SIZE;

  localparam int POOL1_WIDTH  = 12;
  localparam int POOL1_HEIGHT = 12;
  localparam int POOL1_BITS   = 12;

  // Tap 0 is the top-left (oldest) pixel, tap TAPS-1 the newest.
  function automatic int tap_idx(input int r, input int c);
    return FILTER_SIZE * r + c;
  endfunction

endpackage

// File: rtl/conv2_line_buf.sv
// conv2_line_buf: one channel of the conv2 window generator.
//   Holds the last (FILTER_SIZE-1)*WIDTH + FILTER_SIZE pixels of the raster
//   stream and registers a 5x5 window from them when asked.
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset, clears history and window
//   i_valid   i_data holds a pixel; shift it in this cycle
//   i_load    capture the window that includes the pixel on i_data
//   i_data    incoming pixel
//   o_window  registered window, tap k at [k*DATA_BITS +: DATA_BITS]
module conv2_line_buf
  import conv_pkg::*;
#(
  parameter int WIDTH     = POOL1_WIDTH,
  parameter int DATA_BITS = POOL1_BITS
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic                      i_load,
  input  logic [DATA_BITS-1:0]      i_data,
  output logic [TAPS*DATA_BITS-1:0] o_window
);

  localparam int DEPTH = (FILTER_SIZE - 1) * WIDTH + FILTER_SIZE;

  // The newest pixel is taken straight from i_data, so only DEPTH-1
  // entries need storage. w_view is the post-shift view of the history:
  // index 0 is the pixel being accepted, index j the one accepted j ago.
  logic [DATA_BITS-1:0] r_sr   [DEPTH-1];
  logic [DATA_BITS-1:0] w_view [DEPTH];

  always_comb begin
    w_view[0] = i_data;
    for (int j = 1; j < DEPTH; j++) begin
      w_view[j] = r_sr[j-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        r_sr[j] <= '0;
      end
    end else if (i_valid) begin
      r_sr[0] <= i_data;
      for (int j = 1; j < DEPTH - 1; j++) begin
        r_sr[j] <= r_sr[j-1];
      end
    end
  end

  // Window row r, column c sits (4-r) lines and (4-c) pixels behind
  // the newest pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_window <= '0;
    end else if (i_load) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE; c++) begin
          o_window[tap_idx(r, c)*DATA_BITS +: DATA_BITS] <=
            w_view[(FILTER_SIZE - 1 - r) * WIDTH + (FILTER_SIZE - 1 - c)];
        end
      end
    end
  end

endmodule

// File: rtl/conv2_buf.sv
// conv2_buf: 5x5 window generator feeding the conv2 channel calculators.
//   Accepts three pooled conv1 channels as a raster stream and emits a
//   registered window per channel for every pixel at row>=4, col>=4.
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   valid_in       data_in1..3 hold a pixel this cycle
//   data_in1..3    channel pixels
//   window1..3     registered 5x5 windows, tap k at [k*DATA_BITS +: DATA_BITS]
//   valid_out_buf  one-cycle pulse: window1..3 hold a new window
//   frame_done     one-cycle pulse with the last window of a frame
module conv2_buf #(
  parameter int WIDTH       = conv_pkg::POOL1_WIDTH,
  parameter int HEIGHT      = conv_pkg::POOL1_HEIGHT,
  parameter int DATA_BITS   = conv_pkg::POOL1_BITS,
  parameter int FILTER_SIZE = conv_pkg::FILTER_SIZE
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     valid_in,
  input  logic [DATA_BITS-1:0]                     data_in1,
  input  logic [DATA_BITS-1:0]                     data_in2,
  input  logic [DATA_BITS-1:0]                     data_in3,
  output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] window1,
  output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] window2,
  output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] window3,
  output logic                                     valid_out_buf,
  output logic                                     frame_done
);

  import conv_pkg::*;

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(FILTER_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(FILTER_SIZE - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_valid_out;
  logic             r_frame_done;
  logic             w_emit;
  logic             w_last;

  logic [DATA_BITS-1:0]      w_data [CHANNEL_LEN];
  logic [TAPS*DATA_BITS-1:0] w_win  [CHANNEL_LEN];

  // Counters describe the pixel currently on data_in, so the emit
  // decision is made in the same cycle it is accepted.
  assign w_emit = valid_in && (r_row >= ROW_FIRST) && (r_col >= COL_FIRST);
  assign w_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= w_emit;
      r_frame_done <= w_emit && w_last;
    end
  end

  assign w_data[0] = data_in1;
  assign w_data[1] = data_in2;
  assign w_data[2] = data_in3;

  for (genvar g = 0; g < CHANNEL_LEN; g++) begin : g_chan
    conv2_line_buf #(
      .WIDTH     (WIDTH),
      .DATA_BITS (DATA_BITS)
    ) u_line_buf (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (valid_in),
      .i_load   (w_emit),
      .i_data   (w_data[g]),
      .o_window (w_win[g])
    );
  end

  assign window1       = w_win[0];
  assign window2       = w_win[1];
  assign window3       = w_win[2];
  assign valid_out_buf = r_valid_out;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_conv2_buf.sv
// tb_conv2_buf: directed bench for conv2_buf using ramp frames
// (pixel(r,c) = r*16 + c) with hand-derived window expectations.
module tb_conv2_buf;

  localparam int W  = 12;
  localparam int H  = 12;
  localparam int DB = 12;
  localparam int NT = 25;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_in;
  logic [DB-1:0]  d1, d2, d3;
  logic [NT*DB-1:0] win1, win2, win3;
  logic           vout, fdone;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  conv2_buf dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .data_in1      (d1),
    .data_in2      (d2),
    .data_in3      (d3),
    .window1       (win1),
    .window2       (win2),
    .window3       (win3),
    .valid_out_buf (vout),
    .frame_done    (fdone)
  );

  function automatic logic [DB-1:0] ramp(input int r, input int c);
    return DB'(r * 16 + c);
  endfunction

  // Expected window for the pixel accepted at (row, col): tap 5r+c is
  // pixel (row-4+r, col-4+c) of the ramp, plus an offset.
  function automatic logic [NT*DB-1:0] ramp_win(input int row, input int col, input int off);
    logic [NT*DB-1:0] w;
    w = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        w[(5*r+c)*DB +: DB] = DB'((row - 4 + r) * 16 + (col - 4 + c) + off);
      end
    end
    return w;
  endfunction

  // Drive one cycle on the falling edge, then sample 1 ns after the
  // rising edge that consumes it.
  task automatic step(input logic v, input logic [DB-1:0] a, input logic [DB-1:0] b,
                      input logic [DB-1:0] c);
    @(negedge clk);
    valid_in = v;
    d1 = a;
    d2 = b;
    d3 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b1; d1 = 12'hABC; d2 = 12'h123; d3 = 12'h456;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if (vout !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vout); end
    vectors++; if (fdone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", fdone); end
    vectors++; if (win1 !== '0) begin errors++; $display("FAIL reset_win1: got %h want 0", win1); end
    vectors++; if (win2 !== '0) begin errors++; $display("FAIL reset_win2: got %h want 0", win2); end
    vectors++; if (win3 !== '0) begin errors++; $display("FAIL reset_win3: got %h want 0", win3); end
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_ramp();
    int pulses = 0;
    logic ev, ed;
    logic [NT*DB-1:0] exp_w;
    for (int row = 0; row < H; row++) begin
      for (int col = 0; col < W; col++) begin
        step(1'b1, ramp(row, col), ramp(row, col), ramp(row, col));
        ev = (row >= 4) && (col >= 4);
        ed = (row == H - 1) && (col == W - 1);
        if (vout === 1'b1) pulses++;
        vectors++; if (vout !== ev) begin errors++; $display("FAIL ramp_valid (%0d,%0d): got %b want %b", row, col, vout, ev); end
        vectors++; if (fdone !== ed) begin errors++; $display("FAIL ramp_done (%0d,%0d): got %b want %b", row, col, fdone, ed); end
        if (ev) begin
          exp_w = ramp_win(row, col, 0);
          vectors++; if (win1 !== exp_w) begin errors++; $display("FAIL ramp_win1 (%0d,%0d): got %h want %h", row, col, win1, exp_w); end
          vectors++; if (win3 !== exp_w) begin errors++; $display("FAIL ramp_win3 (%0d,%0d): got %h want %h", row, col, win3, exp_w); end
        end
        if (row == 4 && col == 4) begin
          vectors++; if (win1[0*DB +: DB] !== 12'h000) begin errors++; $display("FAIL first_tap0: got %h want 000", win1[0*DB +: DB]); end
          vectors++; if (win1[12*DB +: DB] !== 12'h022) begin errors++; $display("FAIL first_tap12: got %h want 022", win1[12*DB +: DB]); end
          vectors++; if (win1[24*DB +: DB] !== 12'h044) begin errors++; $display("FAIL first_tap24: got %h want 044", win1[24*DB +: DB]); end
        end
        if (ed) begin
          vectors++; if (win1[0*DB +: DB] !== 12'h077) begin errors++; $display("FAIL last_tap0: got %h want 077", win1[0*DB +: DB]); end
          vectors++; if (win1[24*DB +: DB] !== 12'h0BB) begin errors++; $display("FAIL last_tap24: got %h want 0BB", win1[24*DB +: DB]); end
        end
      end
    end
    vectors++; if (pulses != 64) begin errors++; $display("FAIL ramp_pulses: got %0d want 64", pulses); end
  endtask

  task automatic test_stalls();
    int p = 0;
    int pulses = 0;
    int row, col;
    logic ev;
    logic [NT*DB-1:0] last_w;
    last_w = ramp_win(H - 1, W - 1, 0);
    for (int cyc = 0; cyc < 2000 && p < W * H; cyc++) begin
      if ($urandom_range(0, 1) == 0) begin
        step(1'b0, 12'hF0F, 12'h0F0, 12'h5A5);
        vectors++; if (vout !== 1'b0) begin errors++; $display("FAIL stall_valid cyc %0d: got %b want 0", cyc, vout); end
        vectors++; if (fdone !== 1'b0) begin errors++; $display("FAIL stall_done cyc %0d: got %b want 0", cyc, fdone); end
        vectors++; if (win1 !== last_w) begin errors++; $display("FAIL stall_hold cyc %0d: got %h want %h", cyc, win1, last_w); end
      end else begin
        row = p / W;
        col = p % W;
        step(1'b1, ramp(row, col), ramp(row, col), ramp(row, col));
        ev = (row >= 4) && (col >= 4);
        if (vout === 1'b1) pulses++;
        vectors++; if (vout !== ev) begin errors++; $display("FAIL stall_acc_valid (%0d,%0d): got %b want %b", row, col, vout, ev); end
        if (ev) begin
          last_w = ramp_win(row, col, 0);
          vectors++; if (win1 !== last_w) begin errors++; $display("FAIL stall_win (%0d,%0d): got %h want %h", row, col, win1, last_w); end
        end
        p++;
      end
    end
    vectors++; if (p != W * H) begin errors++; $display("FAIL stall_timeout: accepted %0d want %0d", p, W * H); end
    vectors++; if (pulses != 64) begin errors++; $display("FAIL stall_pulses: got %0d want 64", pulses); end
  endtask

  task automatic test_channels();
    logic [NT*DB-1:0] all_fff;
    logic [NT*DB-1:0] exp1, exp2;
    for (int k = 0; k < NT; k++) all_fff[k*DB +: DB] = 12'hFFF;
    for (int row = 0; row < H; row++) begin
      for (int col = 0; col < W; col++) begin
        step(1'b1, ramp(row, col), ramp(row, col) + 12'h100, 12'hFFF);
        if (row >= 4 && col >= 4) begin
          exp1 = ramp_win(row, col, 0);
          exp2 = ramp_win(row, col, 'h100);
          vectors++; if (vout !== 1'b1) begin errors++; $display("FAIL chan_valid (%0d,%0d): got %b want 1", row, col, vout); end
          vectors++; if (win1 !== exp1) begin errors++; $display("FAIL chan_win1 (%0d,%0d): got %h want %h", row, col, win1, exp1); end
          vectors++; if (win2 !== exp2) begin errors++; $display("FAIL chan_win2 (%0d,%0d): got %h want %h", row, col, win2, exp2); end
          vectors++; if (win3 !== all_fff) begin errors++; $display("FAIL chan_win3 (%0d,%0d): got %h want %h", row, col, win3, all_fff); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int pulses = 0;
    logic ev;
    logic [NT*DB-1:0] exp_w;
    for (int p = 0; p <= 6 * W + 7; p++) begin
      step(1'b1, ramp(p / W, p % W), ramp(p / W, p % W), ramp(p / W, p % W));
    end
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b1; d1 = 12'h777; d2 = 12'h777; d3 = 12'h777;
    @(posedge clk); #1;
    vectors++; if (vout !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", vout); end
    vectors++; if (win1 !== '0) begin errors++; $display("FAIL midrst_win1: got %h want 0", win1); end
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    for (int row = 0; row < H; row++) begin
      for (int col = 0; col < W; col++) begin
        step(1'b1, ramp(row, col), ramp(row, col), ramp(row, col));
        ev = (row >= 4) && (col >= 4);
        if (vout === 1'b1) pulses++;
        vectors++; if (vout !== ev) begin errors++; $display("FAIL midrst_frame_valid (%0d,%0d): got %b want %b", row, col, vout, ev); end
        if (ev) begin
          exp_w = ramp_win(row, col, 0);
          vectors++; if (win1 !== exp_w) begin errors++; $display("FAIL midrst_win (%0d,%0d): got %h want %h", row, col, win1, exp_w); end
        end
      end
    end
    vectors++; if (pulses != 64) begin errors++; $display("FAIL midrst_pulses: got %0d want 64", pulses); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int dones = 0;
    logic ev, ed;
    logic [NT*DB-1:0] exp_w;
    logic [NT*DB-1:0] first_w [2];
    for (int f = 0; f < 2; f++) begin
      for (int row = 0; row < H; row++) begin
        for (int col = 0; col < W; col++) begin
          step(1'b1, ramp(row, col), ramp(row, col), ramp(row, col));
          ev = (row >= 4) && (col >= 4);
          ed = (row == H - 1) && (col == W - 1);
          if (vout === 1'b1) pulses++;
          if (fdone === 1'b1) dones++;
          if (row == 4 && col == 4) first_w[f] = win1;
          vectors++; if (vout !== ev) begin errors++; $display("FAIL b2b_valid f%0d (%0d,%0d): got %b want %b", f, row, col, vout, ev); end
          vectors++; if (fdone !== ed) begin errors++; $display("FAIL b2b_done f%0d (%0d,%0d): got %b want %b", f, row, col, fdone, ed); end
          if (ev) begin
            exp_w = ramp_win(row, col, 0);
            vectors++; if (win1 !== exp_w) begin errors++; $display("FAIL b2b_win f%0d (%0d,%0d): got %h want %h", f, row, col, win1, exp_w); end
          end
        end
      end
    end
    exp_w = ramp_win(4, 4, 0);
    vectors++; if (pulses != 128) begin errors++; $display("FAIL b2b_pulses: got %0d want 128", pulses); end
    vectors++; if (dones != 2) begin errors++; $display("FAIL b2b_dones: got %0d want 2", dones); end
    vectors++; if (first_w[1] !== exp_w) begin errors++; $display("FAIL b2b_first_f2: got %h want %h", first_w[1], exp_w); end
  endtask

  task automatic test_row_boundary();
    int acc_idx[$];
    int n = 0;
    logic ev;
    for (int row = 0; row < H; row++) begin
      for (int col = 0; col < W; col++) begin
        step(1'b1, ramp(row, col), ramp(row, col), ramp(row, col));
        n++;
        if (vout === 1'b1) acc_idx.push_back(n);
        ev = (row >= 4) && (col >= 4);
        vectors++; if (vout !== ev) begin errors++; $display("FAIL rowb_valid (%0d,%0d): got %b want %b", row, col, vout, ev); end
      end
    end
    vectors++;
    if (acc_idx.size() != 64) begin
      errors++; $display("FAIL rowb_count: got %0d want 64", acc_idx.size());
    end else begin
      // Pulses 14, 15 are (5,10), (5,11); pulse 16 is (6,4).
      vectors++; if (acc_idx[15] - acc_idx[14] != 1) begin errors++; $display("FAIL rowb_inrow_gap: got %0d want 1", acc_idx[15] - acc_idx[14]); end
      vectors++; if (acc_idx[16] - acc_idx[15] != 5) begin errors++; $display("FAIL rowb_wrap_gap: got %0d want 5", acc_idx[16] - acc_idx[15]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    d1 = '0;
    d2 = '0;
    d3 = '0;
    test_reset();
    test_ramp();
    test_stalls();
    test_channels();
    test_back_to_back();
    test_row_boundary();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
